// File: rtl/fwrisc_csr_rmw.sv
// Zicsr read-modify-write sequencer: splits each CSRRW/CSRRS/CSRRC into
// read, compute, write rd, write CSR over a single register-file write port.
module fwrisc_csr_rmw (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  op,
   input  logic        imm_sel,
   input  logic [4:0]  rs1_idx,
   input  logic [4:0]  zimm,
   input  logic [4:0]  rd_idx,
   input  logic [5:0]  csr_idx,
   output logic [5:0]  ra_raddr,
   input  logic [31:0] ra_rdata,
   output logic [5:0]  rb_raddr,
   input  logic [31:0] rb_rdata,
   output logic [5:0]  rd_waddr,
   output logic [31:0] rd_wdata,
   output logic        rd_wen,
   output logic        done,
   output logic        illegal
);

   typedef enum logic [2:0] {
      S_IDLE, S_READ, S_CALC, S_WR_RD, S_WR_CSR, S_DONE
   } state_t;

   localparam logic [1:0] OP_RW = 2'b01;
   localparam logic [1:0] OP_RS = 2'b10;
   localparam logic [1:0] OP_RC = 2'b11;

   state_t      state, state_nxt;
   logic [1:0]  op_q;
   logic        imm_sel_q;
   logic [4:0]  rs1_q, zimm_q, rd_q;
   logic [5:0]  csr_q;
   logic        wr_rd_q, wr_csr_q, illegal_q;
   logic [31:0] old_q, new_q;

   // Write enables and legality are decided once, from the request fields.
   logic [4:0]  acc_src_idx;
   logic        acc_wr_csr, acc_illegal;
   logic        accept;
   logic [31:0] src_val, new_val;

   assign accept      = (state == S_IDLE) && req_valid;
   assign acc_src_idx = imm_sel ? zimm : rs1_idx;
   assign acc_wr_csr  = (op == OP_RW) || (acc_src_idx != 5'd0);
   assign acc_illegal = (op == 2'b00) || !csr_idx[5] ||
                        (acc_wr_csr && (csr_idx[5:3] == 3'b100));

   assign src_val = imm_sel_q ? {27'b0, zimm_q} : ra_rdata;

   always_comb begin
      case (op_q)
         OP_RS:   new_val = rb_rdata | src_val;
         OP_RC:   new_val = rb_rdata & ~src_val;
         default: new_val = src_val;
      endcase
   end

   // NOTE: only the sequencing state is reset; the latched request and data
   // registers are always rewritten before use, so they carry no reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clock) begin
      if (accept) begin
         op_q      <= op;
         imm_sel_q <= imm_sel;
         rs1_q     <= rs1_idx;
         zimm_q    <= zimm;
         rd_q      <= rd_idx;
         csr_q     <= csr_idx;
         wr_rd_q   <= (rd_idx != 5'd0);
         wr_csr_q  <= acc_wr_csr;
         illegal_q <= acc_illegal;
      end
      if (state == S_CALC) begin
         old_q <= rb_rdata;
         new_q <= new_val;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (req_valid) state_nxt = S_READ;
         S_READ:   state_nxt = S_CALC;
         S_CALC:   state_nxt = S_WR_RD;
         S_WR_RD:  state_nxt = S_WR_CSR;
         S_WR_CSR: state_nxt = S_DONE;
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Outputs are forced to zero while reset is high so an in-flight write
   // is dropped in the very cycle reset arrives.
   always_comb begin
      req_ready = 1'b0;
      ra_raddr  = 6'd0;
      rb_raddr  = 6'd0;
      rd_waddr  = 6'd0;
      rd_wdata  = 32'd0;
      rd_wen    = 1'b0;
      done      = 1'b0;
      illegal   = 1'b0;
      if (!reset) begin
         case (state)
            S_IDLE: req_ready = 1'b1;
            S_READ: begin
               ra_raddr = {1'b0, rs1_q};
               rb_raddr = csr_q;
            end
            S_WR_RD: if (wr_rd_q && !illegal_q) begin
               rd_wen   = 1'b1;
               rd_waddr = {1'b0, rd_q};
               rd_wdata = old_q;
            end
            S_WR_CSR: if (wr_csr_q && !illegal_q) begin
               rd_wen   = 1'b1;
               rd_waddr = csr_q;
               rd_wdata = new_q;
            end
            S_DONE: begin
               done    = 1'b1;
               illegal = illegal_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fwrisc_csr_rmw.sv
// Directed bench for fwrisc_csr_rmw with a small 64-entry register file
// model (1-cycle registered reads, one write port, preload side channel).
module tb_fwrisc_csr_rmw;

   logic        clock, reset, req_valid, req_ready;
   logic [1:0]  op;
   logic        imm_sel;
   logic [4:0]  rs1_idx, zimm, rd_idx;
   logic [5:0]  csr_idx, ra_raddr, rb_raddr, rd_waddr;
   logic [31:0] ra_rdata, rb_rdata, rd_wdata;
   logic        rd_wen, done, illegal;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [64];
   logic        pl_en;
   logic [5:0]  pl_addr;
   logic [31:0] pl_data;

   fwrisc_csr_rmw dut (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .op(op), .imm_sel(imm_sel), .rs1_idx(rs1_idx), .zimm(zimm),
      .rd_idx(rd_idx), .csr_idx(csr_idx),
      .ra_raddr(ra_raddr), .ra_rdata(ra_rdata),
      .rb_raddr(rb_raddr), .rb_rdata(rb_rdata),
      .rd_waddr(rd_waddr), .rd_wdata(rd_wdata), .rd_wen(rd_wen),
      .done(done), .illegal(illegal)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) begin
      ra_rdata <= mem[ra_raddr];
      rb_rdata <= mem[rb_raddr];
      if (rd_wen) mem[rd_waddr] <= rd_wdata;
      if (pl_en)  mem[pl_addr]  <= pl_data;
   end

   task automatic preload(input logic [5:0] a, input logic [31:0] d);
      @(negedge clock);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      @(posedge clock);
      #1 pl_en = 1'b0;
   endtask

   task automatic drive_req(input logic [1:0] o, input logic im, input logic [4:0] rs1,
                            input logic [4:0] zi, input logic [4:0] rd, input logic [5:0] csr);
      op = o; imm_sel = im; rs1_idx = rs1; zimm = zi; rd_idx = rd; csr_idx = csr;
   endtask

   // One full instruction, checked state by state against hand-computed values.
   task automatic run_op(input string nm, input logic [1:0] o, input logic im,
                         input logic [4:0] rs1, input logic [4:0] zi, input logic [4:0] rd,
                         input logic [5:0] csr, input logic e_rd_wen, input logic [31:0] e_rd_data,
                         input logic e_csr_wen, input logic [31:0] e_csr_data, input logic e_ill);
      @(negedge clock);
      drive_req(o, im, rs1, zi, rd, csr);
      req_valid = 1'b1;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++; $display("FAIL %s ready_before: got %b expected 1", nm, req_ready);
      end
      @(posedge clock);
      @(negedge clock);
      req_valid = 1'b0;
      checks++;
      if (ra_raddr !== {1'b0, rs1} || rb_raddr !== csr || req_ready !== 1'b0) begin
         errors++; $display("FAIL %s read_addr: got ra=%h rb=%h rdy=%b expected ra=%h rb=%h rdy=0",
                            nm, ra_raddr, rb_raddr, req_ready, {1'b0, rs1}, csr);
      end
      @(negedge clock);
      checks++;
      if (rd_wen !== 1'b0) begin
         errors++; $display("FAIL %s calc_wen: got %b expected 0", nm, rd_wen);
      end
      @(negedge clock);
      checks++;
      if (rd_wen !== e_rd_wen ||
          (e_rd_wen && (rd_waddr !== {1'b0, rd} || rd_wdata !== e_rd_data))) begin
         errors++; $display("FAIL %s wr_rd: got wen=%b a=%h d=%h expected wen=%b a=%h d=%h",
                            nm, rd_wen, rd_waddr, rd_wdata, e_rd_wen, {1'b0, rd}, e_rd_data);
      end
      @(negedge clock);
      checks++;
      if (rd_wen !== e_csr_wen ||
          (e_csr_wen && (rd_waddr !== csr || rd_wdata !== e_csr_data))) begin
         errors++; $display("FAIL %s wr_csr: got wen=%b a=%h d=%h expected wen=%b a=%h d=%h",
                            nm, rd_wen, rd_waddr, rd_wdata, e_csr_wen, csr, e_csr_data);
      end
      @(negedge clock);
      checks++;
      if (done !== 1'b1 || illegal !== e_ill || rd_wen !== 1'b0) begin
         errors++; $display("FAIL %s done: got done=%b ill=%b wen=%b expected done=1 ill=%b wen=0",
                            nm, done, illegal, rd_wen, e_ill);
      end
      @(negedge clock);
      checks++;
      if (done !== 1'b0 || illegal !== 1'b0 || req_ready !== 1'b1) begin
         errors++; $display("FAIL %s idle: got done=%b ill=%b rdy=%b expected 0 0 1",
                            nm, done, illegal, req_ready);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; req_valid = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
      drive_req(2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 6'd0);
      for (int i = 0; i < 64; i++) mem[i] = 32'd0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      #1;
      checks++;
      if (req_ready !== 1'b1 || done !== 1'b0 || illegal !== 1'b0 || rd_wen !== 1'b0 ||
          rd_waddr !== 6'd0 || rd_wdata !== 32'd0 || ra_raddr !== 6'd0 || rb_raddr !== 6'd0) begin
         errors++; $display("FAIL reset_state: got rdy=%b done=%b ill=%b wen=%b wa=%h wd=%h ra=%h rb=%h expected 1 0 0 0 0 0 0 0",
                            req_ready, done, illegal, rd_wen, rd_waddr, rd_wdata, ra_raddr, rb_raddr);
      end
   endtask

   task automatic test_csrrw();
      preload(6'd5, 32'hDEADBEEF);
      preload(6'h30, 32'h12345678);
      run_op("csrrw", 2'b01, 1'b0, 5'd5, 5'd0, 5'd7, 6'h30,
             1'b1, 32'h12345678, 1'b1, 32'hDEADBEEF, 1'b0);
      checks++;
      if (mem[7] !== 32'h12345678 || mem[6'h30] !== 32'hDEADBEEF) begin
         errors++; $display("FAIL csrrw_mem: got x7=%h csr=%h expected 12345678 deadbeef", mem[7], mem[6'h30]);
      end
   endtask

   task automatic test_csrrs_read();
      preload(6'h30, 32'h000000A5);
      run_op("csrrs_x0", 2'b10, 1'b0, 5'd0, 5'd0, 5'd3, 6'h30,
             1'b1, 32'h000000A5, 1'b0, 32'h0, 1'b0);
      preload(6'h20, 32'h00001000);
      run_op("csrrs_mcycle", 2'b10, 1'b0, 5'd0, 5'd0, 5'd3, 6'h20,
             1'b1, 32'h00001000, 1'b0, 32'h0, 1'b0);
      checks++;
      if (mem[3] !== 32'h00001000 || mem[6'h20] !== 32'h00001000) begin
         errors++; $display("FAIL csrrs_mem: got x3=%h mcycle=%h expected 00001000 00001000", mem[3], mem[6'h20]);
      end
   endtask

   task automatic test_csrrc_imm();
      preload(6'h30, 32'h000000FF);
      run_op("csrrci", 2'b11, 1'b1, 5'd0, 5'h0F, 5'd0, 6'h30,
             1'b0, 32'h0, 1'b1, 32'h000000F0, 1'b0);
      checks++;
      if (mem[6'h30] !== 32'h000000F0) begin
         errors++; $display("FAIL csrrci_mem: got %h expected 000000f0", mem[6'h30]);
      end
   endtask

   task automatic test_illegal();
      run_op("ill_ro_counter", 2'b01, 1'b0, 5'd5, 5'd0, 5'd7, 6'h21,
             1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      run_op("ill_op00", 2'b00, 1'b0, 5'd5, 5'd0, 5'd7, 6'h30,
             1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      run_op("ill_low_idx", 2'b01, 1'b0, 5'd5, 5'd0, 5'd7, 6'h05,
             1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      checks++;
      if (mem[7] !== 32'h12345678 || mem[6'h21] !== 32'h0 || mem[5] !== 32'hDEADBEEF) begin
         errors++; $display("FAIL illegal_mem: got x7=%h r21=%h x5=%h expected 12345678 0 deadbeef",
                            mem[7], mem[6'h21], mem[5]);
      end
   endtask

   task automatic test_rs1_eq_rd();
      preload(6'd9, 32'h1);
      preload(6'h30, 32'h2);
      run_op("rs1_eq_rd", 2'b10, 1'b0, 5'd9, 5'd0, 5'd9, 6'h30,
             1'b1, 32'h2, 1'b1, 32'h3, 1'b0);
      checks++;
      if (mem[9] !== 32'h2 || mem[6'h30] !== 32'h3) begin
         errors++; $display("FAIL rs1_eq_rd_mem: got x9=%h csr=%h expected 2 3", mem[9], mem[6'h30]);
      end
   endtask

   task automatic test_back_to_back();
      preload(6'h31, 32'h77);
      @(negedge clock);
      drive_req(2'b01, 1'b0, 5'd9, 5'd0, 5'd10, 6'h31);
      req_valid = 1'b1;
      @(posedge clock);
      @(negedge clock);
      drive_req(2'b10, 1'b1, 5'd4, 5'h10, 5'd11, 6'h31);
      for (int k = 1; k <= 6; k++) begin
         if (k > 1) @(negedge clock);
         checks++;
         if (req_ready !== (k == 6)) begin
            errors++; $display("FAIL b2b_ready_k%0d: got %b expected %b", k, req_ready, (k == 6));
         end
      end
      @(negedge clock);
      req_valid = 1'b0;
      checks++;
      if (ra_raddr !== 6'd4 || rb_raddr !== 6'h31 || req_ready !== 1'b0) begin
         errors++; $display("FAIL b2b_second_accept: got ra=%h rb=%h rdy=%b expected 04 31 0",
                            ra_raddr, rb_raddr, req_ready);
      end
      repeat (4) @(negedge clock);
      checks++;
      if (done !== 1'b1 || illegal !== 1'b0) begin
         errors++; $display("FAIL b2b_done: got done=%b ill=%b expected 1 0", done, illegal);
      end
      checks++;
      if (mem[10] !== 32'h77 || mem[11] !== 32'h2 || mem[6'h31] !== 32'h12) begin
         errors++; $display("FAIL b2b_mem: got x10=%h x11=%h csr=%h expected 77 2 12",
                            mem[10], mem[11], mem[6'h31]);
      end
      @(negedge clock);
   endtask

   task automatic test_reset_mid();
      preload(6'h30, 32'h55);
      @(negedge clock);
      drive_req(2'b01, 1'b0, 5'd5, 5'd0, 5'd6, 6'h30);
      req_valid = 1'b1;
      @(posedge clock);
      @(negedge clock);
      req_valid = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      #1;
      checks++;
      if (rd_wen !== 1'b0 || rd_waddr !== 6'd0 || rd_wdata !== 32'd0 || done !== 1'b0 ||
          ra_raddr !== 6'd0 || rb_raddr !== 6'd0) begin
         errors++; $display("FAIL mid_reset_outputs: got wen=%b wa=%h wd=%h done=%b expected all 0",
                            rd_wen, rd_waddr, rd_wdata, done);
      end
      @(negedge clock);
      reset = 1'b0;
      #1;
      checks++;
      if (req_ready !== 1'b1 || rd_wen !== 1'b0) begin
         errors++; $display("FAIL mid_reset_ready: got rdy=%b wen=%b expected 1 0", req_ready, rd_wen);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         checks++;
         if (rd_wen !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL mid_reset_quiet_%0d: got wen=%b done=%b expected 0 0", k, rd_wen, done);
         end
      end
      checks++;
      if (mem[6'h30] !== 32'h55) begin
         errors++; $display("FAIL mid_reset_csr: got %h expected 00000055", mem[6'h30]);
      end
   endtask

   initial begin
      test_reset();
      test_csrrw();
      test_csrrs_read();
      test_csrrc_imm();
      test_illegal();
      test_rs1_eq_rd();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
